// File: rtl/ctrl_unit_fsm_pkg.sv
// Shared definitions for the multi-cycle control unit: state encodings,
// opcode/funct/ALU codes, CTRL bit positions and the decoded control record.
package ctrl_unit_fsm_pkg;

   localparam int CTRL_W = 32;
   localparam int OPRN_W = 6;

   localparam logic [2:0] ST_FETCH     = 3'd0;
   localparam logic [2:0] ST_DECODE    = 3'd1;
   localparam logic [2:0] ST_EXECUTE   = 3'd2;
   localparam logic [2:0] ST_MEMORY    = 3'd3;
   localparam logic [2:0] ST_WRITEBACK = 3'd4;

   // Every select steers its mux to the special input when 1, e.g. pc_sel_3 -> jump
   // target, op2_sel_4 -> R2, wa_sel_2 -> r31, wa_sel_3 -> r0, wd_sel_3 -> PC+1.
   localparam int CTRL_PC_SEL_1  = 0;
   localparam int CTRL_PC_SEL_2  = 1;
   localparam int CTRL_PC_SEL_3  = 2;
   localparam int CTRL_R1_SEL_1  = 3;
   localparam int CTRL_OP1_SEL_1 = 4;
   localparam int CTRL_OP2_SEL_1 = 5;
   localparam int CTRL_OP2_SEL_2 = 6;
   localparam int CTRL_OP2_SEL_3 = 7;
   localparam int CTRL_OP2_SEL_4 = 8;
   localparam int CTRL_WA_SEL_1  = 9;
   localparam int CTRL_WA_SEL_2  = 10;
   localparam int CTRL_WA_SEL_3  = 11;
   localparam int CTRL_PC_LOAD   = 12;
   localparam int CTRL_IR_LOAD   = 13;
   localparam int CTRL_REG_R     = 14;
   localparam int CTRL_REG_W     = 15;
   localparam int CTRL_ALU_LSB   = 16;
   localparam int CTRL_MD_SEL_1  = 22;
   localparam int CTRL_SP_LOAD   = 23;
   localparam int CTRL_MA_SEL_1  = 24;
   localparam int CTRL_MA_SEL_2  = 25;
   localparam int CTRL_WD_SEL_1  = 26;
   localparam int CTRL_WD_SEL_2  = 27;
   localparam int CTRL_WD_SEL_3  = 28;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_MULI  = 6'h1D;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_JMP   = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_PUSH  = 6'h1B;
   localparam logic [5:0] OP_POP   = 6'h1C;

   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_MUL = 6'h2C;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_NOR = 6'h27;
   localparam logic [5:0] FN_SLT = 6'h2A;
   localparam logic [5:0] FN_SLL = 6'h01;
   localparam logic [5:0] FN_SRL = 6'h02;
   localparam logic [5:0] FN_JR  = 6'h08;

   localparam logic [OPRN_W-1:0] ALU_ADD = 6'd1;
   localparam logic [OPRN_W-1:0] ALU_SUB = 6'd2;
   localparam logic [OPRN_W-1:0] ALU_MUL = 6'd3;
   localparam logic [OPRN_W-1:0] ALU_SHR = 6'd4;
   localparam logic [OPRN_W-1:0] ALU_SHL = 6'd5;
   localparam logic [OPRN_W-1:0] ALU_AND = 6'd6;
   localparam logic [OPRN_W-1:0] ALU_OR  = 6'd7;
   localparam logic [OPRN_W-1:0] ALU_NOR = 6'd8;
   localparam logic [OPRN_W-1:0] ALU_SLT = 6'd9;

   // op2_sel[0] is op2_sel_1 ... op2_sel[3] is op2_sel_4; same indexing for wa/wd.
   typedef struct packed {
      logic              r1_sel_1;
      logic              op1_sel_1;
      logic [3:0]        op2_sel;
      logic [OPRN_W-1:0] alu_oprn;
      logic              mem_read;
      logic              mem_write;
      logic              md_sel_1;
      logic              ma_sel_1;
      logic              reg_w;
      logic [2:0]        wa_sel;
      logic [2:0]        wd_sel;
      logic              pc_sel_1;
      logic              pc_sel_3;
      logic              br_eq;
      logic              br_ne;
      logic              sp_load;
   } dec_ctrl_t;

endpackage

// File: rtl/ctrl_unit_fsm_decode.sv
// Pure combinational opcode/funct decode into the per-state control record;
// unknown encodings decode to all-zero (NOP).
module ctrl_unit_fsm_decode
   import ctrl_unit_fsm_pkg::*;
(
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   output dec_ctrl_t  dec
);

   function automatic dec_ctrl_t r_alu(input logic [OPRN_W-1:0] code);
      dec_ctrl_t d;
      d          = '0;
      d.op2_sel  = 4'b1000;
      d.alu_oprn = code;
      d.reg_w    = 1'b1;
      return d;
   endfunction

   function automatic dec_ctrl_t r_shift(input logic [OPRN_W-1:0] code);
      dec_ctrl_t d;
      d          = '0;
      d.op2_sel  = 4'b0101;
      d.alu_oprn = code;
      d.reg_w    = 1'b1;
      return d;
   endfunction

   // Immediate ALU ops write rt; sext picks sign- over zero-extension.
   function automatic dec_ctrl_t i_alu(input logic [OPRN_W-1:0] code, input logic sext);
      dec_ctrl_t d;
      d          = '0;
      d.op2_sel  = {2'b00, sext, 1'b0};
      d.alu_oprn = code;
      d.reg_w    = 1'b1;
      d.wa_sel   = 3'b001;
      return d;
   endfunction

   // Opcode/funct decode
   always_comb begin
      dec = '0;
      case (opcode)
         OP_RTYPE: begin
            case (funct)
               FN_ADD:  dec = r_alu(ALU_ADD);
               FN_SUB:  dec = r_alu(ALU_SUB);
               FN_MUL:  dec = r_alu(ALU_MUL);
               FN_AND:  dec = r_alu(ALU_AND);
               FN_OR:   dec = r_alu(ALU_OR);
               FN_NOR:  dec = r_alu(ALU_NOR);
               FN_SLT:  dec = r_alu(ALU_SLT);
               FN_SLL:  dec = r_shift(ALU_SHL);
               FN_SRL:  dec = r_shift(ALU_SHR);
               FN_JR:   dec.pc_sel_1 = 1'b1;
               default: dec = '0;
            endcase
         end
         OP_ADDI: dec = i_alu(ALU_ADD, 1'b1);
         OP_MULI: dec = i_alu(ALU_MUL, 1'b1);
         OP_ANDI: dec = i_alu(ALU_AND, 1'b0);
         OP_ORI:  dec = i_alu(ALU_OR,  1'b0);
         OP_SLTI: dec = i_alu(ALU_SLT, 1'b1);
         OP_LUI: begin
            dec.reg_w  = 1'b1;
            dec.wa_sel = 3'b001;
            dec.wd_sel = 3'b010;
         end
         OP_BEQ: begin
            dec.op2_sel  = 4'b1000;
            dec.alu_oprn = ALU_SUB;
            dec.br_eq    = 1'b1;
         end
         OP_BNE: begin
            dec.op2_sel  = 4'b1000;
            dec.alu_oprn = ALU_SUB;
            dec.br_ne    = 1'b1;
         end
         OP_LW: begin
            dec          = i_alu(ALU_ADD, 1'b1);
            dec.mem_read = 1'b1;
            dec.wd_sel   = 3'b001;
         end
         OP_SW: begin
            dec.op2_sel   = 4'b0010;
            dec.alu_oprn  = ALU_ADD;
            dec.mem_write = 1'b1;
         end
         OP_JMP: dec.pc_sel_3 = 1'b1;
         OP_JAL: begin
            dec.pc_sel_3 = 1'b1;
            dec.reg_w    = 1'b1;
            dec.wa_sel   = 3'b010;
            dec.wd_sel   = 3'b100;
         end
         // Push stores r0 at SP then SP-1; pop reads at SP+1 into r0 then SP+1.
         OP_PUSH: begin
            dec.r1_sel_1  = 1'b1;
            dec.op1_sel_1 = 1'b1;
            dec.op2_sel   = 4'b0100;
            dec.alu_oprn  = ALU_SUB;
            dec.mem_write = 1'b1;
            dec.md_sel_1  = 1'b1;
            dec.ma_sel_1  = 1'b1;
            dec.sp_load   = 1'b1;
         end
         OP_POP: begin
            dec.op1_sel_1 = 1'b1;
            dec.op2_sel   = 4'b0100;
            dec.alu_oprn  = ALU_ADD;
            dec.mem_read  = 1'b1;
            dec.sp_load   = 1'b1;
            dec.reg_w     = 1'b1;
            dec.wa_sel    = 3'b100;
            dec.wd_sel    = 3'b001;
         end
         default: dec = '0;
      endcase
   end

endmodule

// File: rtl/ctrl_unit_fsm.sv
// Five-state multi-cycle control unit: sequences FETCH..WRITEBACK and builds the
// datapath control word and memory strobes from the state and current IR.
module ctrl_unit_fsm
   import ctrl_unit_fsm_pkg::*;
#(
   parameter int CTRL_WIDTH = CTRL_W,
   parameter int OPRN_WIDTH = OPRN_W
)(
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [31:0]           INSTRUCTION,
   input  logic                  ZERO,
   output logic [CTRL_WIDTH-1:0] CTRL,
   output logic                  READ,
   output logic                  WRITE
);

   logic [2:0]            state_r;
   logic [2:0]            state_next_s;
   logic                  zero_r;
   dec_ctrl_t             dec_s;
   logic [CTRL_WIDTH-1:0] exe_bits_s;
   logic [CTRL_WIDTH-1:0] ctrl_s;
   logic                  read_s;
   logic                  write_s;
   logic                  take_s;
   logic                  unused_ir_s;

   assign unused_ir_s = ^INSTRUCTION[25:6];

   ctrl_unit_fsm_decode u_decode (
      .opcode (INSTRUCTION[31:26]),
      .funct  (INSTRUCTION[5:0]),
      .dec    (dec_s)
   );

   // Fixed five-step sequence, no stalls or early exits
   always_comb begin
      state_next_s = ST_FETCH;
      case (state_r)
         ST_FETCH:     state_next_s = ST_DECODE;
         ST_DECODE:    state_next_s = ST_EXECUTE;
         ST_EXECUTE:   state_next_s = ST_MEMORY;
         ST_MEMORY:    state_next_s = ST_WRITEBACK;
         ST_WRITEBACK: state_next_s = ST_FETCH;
         default:      state_next_s = ST_FETCH;
      endcase
   end

   // State register
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_r <= ST_FETCH;
      end else begin
         state_r <= state_next_s;
      end
   end

   // ALU zero flag captured at the end of EXECUTE for the WRITEBACK branch decision
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         zero_r <= 1'b0;
      end else if (state_r == ST_EXECUTE) begin
         zero_r <= ZERO;
      end else begin
         zero_r <= zero_r;
      end
   end

   // Operand/ALU selects, driven in EXECUTE and held through WRITEBACK
   always_comb begin
      exe_bits_s                               = '0;
      exe_bits_s[CTRL_OP1_SEL_1]               = dec_s.op1_sel_1;
      exe_bits_s[CTRL_OP2_SEL_1]               = dec_s.op2_sel[0];
      exe_bits_s[CTRL_OP2_SEL_2]               = dec_s.op2_sel[1];
      exe_bits_s[CTRL_OP2_SEL_3]               = dec_s.op2_sel[2];
      exe_bits_s[CTRL_OP2_SEL_4]               = dec_s.op2_sel[3];
      exe_bits_s[CTRL_ALU_LSB +: OPRN_WIDTH]   = dec_s.alu_oprn;
   end

   assign take_s = (dec_s.br_eq & zero_r) | (dec_s.br_ne & ~zero_r);

   // Per-state control word and strobes
   always_comb begin
      ctrl_s  = '0;
      read_s  = 1'b0;
      write_s = 1'b0;
      case (state_r)
         ST_FETCH: begin
            read_s                = 1'b1;
            ctrl_s[CTRL_MA_SEL_2] = 1'b1;
            ctrl_s[CTRL_IR_LOAD]  = 1'b1;
         end
         ST_DECODE: begin
            ctrl_s[CTRL_REG_R]    = 1'b1;
            ctrl_s[CTRL_R1_SEL_1] = dec_s.r1_sel_1;
         end
         ST_EXECUTE: begin
            ctrl_s                = exe_bits_s;
            ctrl_s[CTRL_REG_R]    = 1'b1;
            ctrl_s[CTRL_R1_SEL_1] = dec_s.r1_sel_1;
         end
         ST_MEMORY: begin
            ctrl_s                = exe_bits_s;
            ctrl_s[CTRL_MD_SEL_1] = dec_s.md_sel_1;
            ctrl_s[CTRL_MA_SEL_1] = dec_s.ma_sel_1;
            read_s                = dec_s.mem_read;
            write_s               = dec_s.mem_write & ~dec_s.mem_read;
         end
         ST_WRITEBACK: begin
            ctrl_s                = exe_bits_s;
            ctrl_s[CTRL_PC_LOAD]  = 1'b1;
            ctrl_s[CTRL_PC_SEL_1] = dec_s.pc_sel_1;
            ctrl_s[CTRL_PC_SEL_2] = take_s;
            ctrl_s[CTRL_PC_SEL_3] = dec_s.pc_sel_3;
            ctrl_s[CTRL_REG_W]    = dec_s.reg_w;
            ctrl_s[CTRL_WA_SEL_1] = dec_s.wa_sel[0];
            ctrl_s[CTRL_WA_SEL_2] = dec_s.wa_sel[1];
            ctrl_s[CTRL_WA_SEL_3] = dec_s.wa_sel[2];
            ctrl_s[CTRL_WD_SEL_1] = dec_s.wd_sel[0];
            ctrl_s[CTRL_WD_SEL_2] = dec_s.wd_sel[1];
            ctrl_s[CTRL_WD_SEL_3] = dec_s.wd_sel[2];
            ctrl_s[CTRL_SP_LOAD]  = dec_s.sp_load;
         end
         default: begin
            ctrl_s  = '0;
            read_s  = 1'b0;
            write_s = 1'b0;
         end
      endcase
   end

   // Everything is forced quiet while reset is held, even though the state already reads FETCH
   assign CTRL  = RST ? '0   : ctrl_s;
   assign READ  = RST ? 1'b0 : read_s;
   assign WRITE = RST ? 1'b0 : write_s;

endmodule
